// File: rtl/mix_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mix_sequencer
//  Description : Sequenced 8x32-bit mixing engine. One phase per clock (ADD,
//                CROSS/XOR/SHR, FOLD), then a single SCALE step, with a
//                start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module mix_sequencer #(
    parameter int ADD_ROUNDS   = 7,
    parameter int CROSS_ROUNDS = 11,
    parameter int FOLD_ROUNDS  = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [255:0] in_data,
    output logic         busy,
    output logic         done,
    output logic [255:0] out_data
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ADD   = 3'd1;
    localparam logic [2:0] c_ST_CROSS = 3'd2;
    localparam logic [2:0] c_ST_XOR   = 3'd3;
    localparam logic [2:0] c_ST_SHR   = 3'd4;
    localparam logic [2:0] c_ST_FOLD  = 3'd5;
    localparam logic [2:0] c_ST_SCALE = 3'd6;
    localparam logic [2:0] c_ST_DONE  = 3'd7;

    localparam logic [7:0] c_ADD_LAST   = 8'(ADD_ROUNDS - 1);
    localparam logic [7:0] c_CROSS_LAST = 8'(CROSS_ROUNDS - 1);
    localparam logic [7:0] c_FOLD_LAST  = 8'(FOLD_ROUNDS - 1);

    // Phase groups with a zero round count are skipped at elaboration time.
    localparam logic [2:0] c_AFTER_CROSS = (FOLD_ROUNDS  != 0) ? c_ST_FOLD  : c_ST_SCALE;
    localparam logic [2:0] c_AFTER_ADD   = (CROSS_ROUNDS != 0) ? c_ST_CROSS : c_AFTER_CROSS;
    localparam logic [2:0] c_FIRST       = (ADD_ROUNDS   != 0) ? c_ST_ADD   : c_AFTER_ADD;

    localparam logic [255:0] c_SCALE_A = {32'd19, 32'd17, 32'd13, 32'd11,
                                          32'd7,  32'd5,  32'd3,  32'd2};
    localparam logic [255:0] c_SCALE_B = {32'd23, 32'd19, 32'd17, 32'd13,
                                          32'd11, 32'd7,  32'd5,  32'd3};

    function automatic logic [31:0] f_word(input logic [255:0] s, input logic [2:0] k);
        return s[{k, 5'd0} +: 32];
    endfunction

    // Words are rewritten in place so later words see earlier updated ones.
    function automatic logic [255:0] f_phase(input logic [2:0] op, input logic [255:0] s);
        logic [255:0] r;
        logic [31:0]  v;
        r = s;
        if (op == c_ST_ADD) begin
            for (int i = 0; i < 8; i++) begin
                r[{3'(i), 5'd0} +: 32] = f_word(r, 3'(i)) + 32'(i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            v = f_word(r, 3'(i));
            case (op)
                c_ST_ADD:   v = v + f_word(r, 3'(i + 7));
                c_ST_CROSS: v = v + f_word(r, 3'(i + 1)) - f_word(r, 3'(i + 5));
                c_ST_XOR:   v = v ^ (f_word(r, 3'(i + 3)) << 16);
                c_ST_SHR:   v = v - (f_word(r, 3'(i + 2)) >> 17) + (f_word(r, 3'(i + 4)) >> 12);
                c_ST_FOLD:  v = v + f_word(r, 3'(i + 7)) - f_word(r, 3'(i + 6));
                c_ST_SCALE: v = v * f_word(c_SCALE_A, 3'(i)) + f_word(c_SCALE_B, 3'(i));
                default:    v = v;
            endcase
            r[{3'(i), 5'd0} +: 32] = v;
        end
        return r;
    endfunction

    logic [2:0]   r_state;
    logic [2:0]   w_state_nxt;
    logic [7:0]   r_cnt;
    logic [7:0]   w_cnt_nxt;
    logic [255:0] r_work;
    logic [255:0] r_out;
    logic         r_busy;
    logic         r_done;
    logic         w_running;
    logic         w_nxt_running;

    assign w_running     = (r_state != c_ST_IDLE) && (r_state != c_ST_DONE);
    assign w_nxt_running = (w_state_nxt != c_ST_IDLE) && (w_state_nxt != c_ST_DONE);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_FIRST;
                    w_cnt_nxt   = 8'd0;
                end
            end
            c_ST_ADD: begin
                if (r_cnt == c_ADD_LAST) begin
                    w_state_nxt = c_AFTER_ADD;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            c_ST_CROSS: w_state_nxt = c_ST_XOR;
            c_ST_XOR:   w_state_nxt = c_ST_SHR;
            c_ST_SHR: begin
                if (r_cnt == c_CROSS_LAST) begin
                    w_state_nxt = c_AFTER_CROSS;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_state_nxt = c_ST_CROSS;
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end
            c_ST_FOLD: begin
                if (r_cnt == c_FOLD_LAST) begin
                    w_state_nxt = c_ST_SCALE;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            c_ST_SCALE: w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
        if (abort && w_running) begin
            w_state_nxt = c_ST_IDLE;
            w_cnt_nxt   = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 8'd0;
            r_work  <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_nxt_running;
            r_done  <= (w_state_nxt == c_ST_DONE);
            case (r_state)
                c_ST_IDLE: begin
                    if (start) r_work <= in_data;
                end
                c_ST_ADD, c_ST_CROSS, c_ST_XOR, c_ST_SHR, c_ST_FOLD: begin
                    r_work <= f_phase(r_state, r_work);
                end
                c_ST_SCALE: begin
                    if (!abort) r_out <= f_phase(c_ST_SCALE, r_work);
                end
                default: r_work <= r_work;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign out_data = r_out;

endmodule
`default_nettype wire
